// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a small input FIFO; frames stream back-to-back while data is queued.
// Define UART_TX_PARITY_EN to add an even-parity bit after bit 7 (11-bit frames).
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam int BC_W = $clog2(CLKS_PER_BIT);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   FULL    = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef UART_TX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [BC_W-1:0] bc_q, bc_d;
    logic [2:0]      bi_q, bi_d;
    logic [7:0]      sh_q, sh_d;
    logic            tx_q, tx_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic            push, pop, bit_end;

    assign tx_ready   = (count_q != FULL);
    assign push       = tx_valid && tx_ready;
    assign bit_end    = (bc_q == BC_LAST);
    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE) || (count_q != '0);
    assign fifo_count = count_q;

    // tx_d depends only on registered state, so the line flop sees no input-driven path.
    always_comb begin
        state_d = state_q;
        bc_d    = bit_end ? '0 : bc_q + 1'b1;
        bi_d    = bi_q;
        tx_d    = 1'b1;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                bc_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    state_d = S_DATA;
                    bi_d    = '0;
                end
            end
            S_DATA: begin
                tx_d = sh_q[bi_q];
                if (bit_end) begin
                    if (bi_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bi_d = bi_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                tx_d = ^sh_q;
                if (bit_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                bc_d    = '0;
            end
        endcase
        if (pop) bc_d = '0;
        sh_d = pop ? mem_q[rd_ptr_q] : sh_q;
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            bc_q     <= '0;
            bi_q     <= '0;
            sh_q     <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            bc_q     <= bc_d;
            bi_q     <= bi_d;
            sh_q     <= sh_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the cleared pointers make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tx_data;
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: a frame-schedule model predicts line, busy, count and ready every cycle.
module tb_uart_transmitter;
    localparam int C = 4;
    localparam int D = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx, busy;
    logic [2:0] fifo_count;

    always #5 clk = ~clk;

    uart_transmitter #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mcount = 0;
    int last_pop = -1000;
    int saw_not_ready = 0;
    logic [7:0] f_data[$];
    int         f_pop[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Frame popped at edge p occupies the line after edges p+1 .. p+FRAME.
    function automatic logic exp_tx(input int e);
        int o;
        foreach (f_pop[i]) begin
            if (e >= f_pop[i] + 1 && e <= f_pop[i] + FRAME) begin
                o = (e - f_pop[i] - 1) / C;
                if (o == 0) return 1'b0;
                if (o <= 8) return f_data[i][o-1];
`ifdef UART_TX_PARITY_EN
                if (o == 9) return ^f_data[i];
`endif
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int e);
        if (mcount != 0) return 1'b1;
        foreach (f_pop[i])
            if (e >= f_pop[i] && e <= f_pop[i] + FRAME - 1) return 1'b1;
        return 1'b0;
    endfunction

    // Advance one clock edge: update the model, then check all outputs at the negedge.
    task automatic step(output bit accepted);
        int e;
        int p;
        bit push, pop;
        e = cyc + 1;
        accepted = 1'b0;
        if (rst) begin
            f_data.delete();
            f_pop.delete();
            mcount = 0;
            last_pop = -1000;
        end else begin
            push = tx_valid && (mcount != D);
            pop = 1'b0;
            foreach (f_pop[i]) if (f_pop[i] == e) pop = 1'b1;
            if (push) begin
                p = (last_pop + FRAME > e + 1) ? last_pop + FRAME : e + 1;
                f_data.push_back(tx_data);
                f_pop.push_back(p);
                last_pop = p;
                accepted = 1'b1;
            end
            mcount = mcount + int'(push) - int'(pop);
        end
        @(posedge clk);
        cyc = e;
        @(negedge clk);
        chk("tx", tx, exp_tx(e));
        chk("busy", busy, exp_busy(e));
        chk("fifo_count", fifo_count, mcount);
        chk("tx_ready", tx_ready, (mcount != D));
        if (tx_ready === 1'b0) saw_not_ready++;
    endtask

    task automatic idle(input int n);
        bit a;
        tx_valid = 1'b0;
        repeat (n) step(a);
    endtask

    task automatic send(input logic [7:0] b);
        bit acc;
        int guard;
        acc = 1'b0;
        guard = 0;
        tx_valid = 1'b1;
        tx_data = b;
        while (!acc && guard < 400) begin
            step(acc);
            guard++;
        end
        if (!acc) chk("send_timeout", 0, 1);
        tx_valid = 1'b0;
    endtask

    task automatic drain();
        idle(last_pop + FRAME + 2 - cyc > 0 ? last_pop + FRAME + 2 - cyc : 1);
        chk("drain_busy", busy, 0);
        chk("drain_tx", tx, 1);
    endtask

    initial begin
        bit a;
        int p0;
        // reset with valid asserted: nothing may be accepted
        rst = 1'b1;
        tx_valid = 1'b1;
        tx_data = 8'hC3;
        repeat (3) step(a);
        rst = 1'b0;
        tx_valid = 1'b0;
        chk("rst_tx", tx, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        idle(10);

        // single byte: line falls two edges after the push
        send(8'hA5);
        step(a);
        chk("a5_pre", tx, 1);
        step(a);
        chk("a5_fall", tx, 0);
        drain();

        // back-to-back, filling the FIFO
        saw_not_ready = 0;
        send(8'h00); send(8'hFF); send(8'h55); send(8'h7E); send(8'h81);
        drain();
        chk("full_seen", (saw_not_ready > 0), 1);

        // push on the last STOP cycle while one byte waits
        send(8'h11);
        send(8'h22);
        while (cyc + 1 < last_pop) step(a);
        tx_valid = 1'b1;
        tx_data = 8'h33;
        step(a);
        tx_valid = 1'b0;
        chk("simul_acc", a, 1);
        chk("simul_count", fifo_count, 1);
        drain();

        // randomized traffic with random gaps
        repeat (25) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 50));
            send(8'($urandom));
        end
        drain();

        // parity-sensitive bytes
        send(8'h07);
        send(8'h03);
        drain();

        // reset during data bit 3 with two bytes queued
        send(8'h3C);
        p0 = last_pop;
        send(8'h96);
        send(8'h69);
        while (cyc + 1 < p0 + 4 * C + 2) step(a);
        rst = 1'b1;
        step(a);
        rst = 1'b0;
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_busy", busy, 0);
        idle(3 * FRAME);
        chk("mid_rst_quiet", tx, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Byte-serialising UART transmitter that drives the serial line consumed by the UART receiver stage. Accepts bytes over a valid/ready handshake into a small FIFO and shifts each byte out as an 8N1 frame: start bit, eight data bits LSB first, optional parity bit, one stop bit. Frames stream back-to-back with no idle gap while the FIFO holds data, so the receiver's phase-word sequence can be fed continuously.

## Interface
- CLKS_PER_BIT, 434, clock cycles per serial bit (434 gives 115200 baud at 50 MHz); legal range 2 to 65535
- FIFO_DEPTH, 4, input FIFO entries; must be a power of 2 and at least 2
- clk  input  1  system clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- tx_data  input  8  byte to transmit
- tx_valid  input  1  tx_data is valid this cycle
- tx_ready  output  1  FIFO can accept a byte; equals (fifo_count != FIFO_DEPTH); reset value 1
- tx  output  1  serial line; idles high; reset value 1
- busy  output  1  high when state != IDLE or fifo_count != 0; reset value 0
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes in the FIFO; reset value 0

## Operation
- Push: on an edge where tx_valid && tx_ready, tx_data is written at the write pointer. The pointer wraps modulo FIFO_DEPTH.
- When tx_ready is 0, tx_valid is ignored and the byte is dropped with no side effect. The producer holds the byte until it sees ready.
- Pop: the FSM removes the head byte into shift register sh and loads baud counter bc = 0.
- Push and pop on the same edge: fifo_count is unchanged and both pointers advance.
- A full FIFO deasserts tx_ready, so a push and pop can never coincide at full.
- FSM states:
  - IDLE: tx = 1. If fifo_count != 0, pop and go to START.
  - START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index bi = 0.
  - DATA: tx = sh[bi] for CLKS_PER_BIT cycles each. After bi = 7, go to PARITY (macro defined) or STOP.
  - PARITY: tx = ^byte (even parity) for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx = 1 for CLKS_PER_BIT cycles. On the last cycle, if fifo_count != 0, pop and go directly to START; otherwise go to IDLE.
- Counter rules:
  - bc counts 0..CLKS_PER_BIT-1; a bit ends on the cycle where bc == CLKS_PER_BIT-1.
  - bc width is $clog2(CLKS_PER_BIT).
  - bi is 3 bits.
- tx is driven from a register with no combinational path from inputs, so the line is glitch-free.
- Reset mid-frame: rst aborts the frame on the next edge.
  - tx returns to 1 and the FSM goes to IDLE.
  - The FIFO is emptied and its pointers are cleared.
  - The partially sent byte is discarded.
- Default/illegal state: go to IDLE with tx = 1.

## Timing
- Latency: a byte pushed at edge k into an empty FIFO with the FSM in IDLE is popped at edge k+1. tx falls at edge k+2.
- Frame length: 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.
- Back-to-back frames: the start bit of the next frame begins on the edge immediately after the final stop-bit cycle, with zero idle cycles.
- tx_ready reflects the registered fifo_count. It rises on the edge after a pop from a full FIFO.

## Configuration
- UART_TX_PARITY_EN:
  - Defined: the PARITY state is compiled in and each frame carries an even-parity bit after bit 7 (11 bits per frame).
  - Undefined: PARITY logic is absent and frames are 8N1 (10 bits), matching the receiver stage as built today.

## Test plan
- Reset: rst high for 3 cycles with tx_valid = 1 → tx = 1, tx_ready = 1, busy = 0, fifo_count = 0, and nothing transmitted.
- Single byte: CLKS_PER_BIT = 4, push 0xA5 → tx falls 2 cycles later. The line carries bits 1,0,1,0,0,1,0,1 (LSB first), 4 cycles each, then high. Total 40 cycles low-to-idle; busy drops on the following cycle.
- Back-to-back and full: push 0x00, 0xFF, 0x55, 0x7E, 0x81 on consecutive cycles with FIFO_DEPTH = 4.
  - tx_ready = 0 is seen while the FIFO is full, and the fifth byte is held until accepted.
  - All five frames appear with no idle gap between stop and start bits.
- Simultaneous push and pop: push exactly on the last STOP cycle with fifo_count = 1 → fifo_count stays 1 and the next START begins immediately.
- Reset mid-frame: assert rst during DATA bit 3 of 0x3C with 2 bytes queued → tx = 1 next edge, fifo_count = 0, and no further frames.
- Parity build (UART_TX_PARITY_EN): send 0x07 → parity bit 1; send 0x03 → parity bit 0. Each frame is 11*CLKS_PER_BIT cycles.
